// File: rtl/gi_input_fifo.sv
// gi_input_fifo
// Single-clock first-word-fall-through FIFO that sits between an upstream
// loader and a downstream read mux. Occupancy is tracked in a registered
// count from which all status outputs are decoded, so full_n/empty_n/
// almost_full are glitch-free registered functions of state.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (highest priority)
//   clear        synchronous flush pulse (priority over write/read)
//   din/write    write data and write request from the loader
//   full_n       high while at least one entry is free
//   almost_full  high while count >= AF_LEVEL
//   dout         head-of-queue word, valid while empty_n is high
//   empty_n      high while dout holds a valid word
//   read         pop request from the downstream mux
//   count        current occupancy, 0..DEPTH
//   ovf_err      sticky: a write was attempted while full
//   udf_err      sticky: a read was attempted while empty
module gi_input_fifo #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  input  logic              write,
  output logic              full_n,
  output logic              almost_full,
  output logic [DATA_W-1:0] dout,
  output logic              empty_n,
  input  logic              read,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // Status flags come straight from the registered count. A write is only
  // accepted against the full_n seen at the start of the cycle, so a
  // simultaneous read does not make room for a write when full; likewise
  // a read is not satisfied by a same-cycle write into an empty FIFO.
  always_comb begin
    full_n      = (count_q != DEPTH_C);
    empty_n     = (count_q != '0);
    almost_full = (count_q >= AF_C);
    count       = count_q;
    ovf_err     = ovf_q;
    udf_err     = udf_q;
    dout        = mem[rd_ptr_q];
    wr_acc      = write && full_n;
    rd_acc      = read && empty_n;
  end

  // Next-state logic. Clear wins over any same-cycle traffic and also
  // suppresses error reporting for that traffic. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + (ADDR_W+1)'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - (ADDR_W+1)'(1);
      end
      if (write && !full_n) begin
        ovf_d = 1'b1;
      end
      if (read && !empty_n) begin
        udf_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is deliberately not reset so it can map onto RAM; a
  // write coinciding with reset or clear is dropped.
  always_ff @(posedge clk) begin
    if (!reset && !clear && wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule
